// File: rtl/synch_down_counter_pkg.sv
// Shared definitions for the loadable synchronous down counter: width limit,
// mode encodings and an all-ones mask helper.
package synch_down_counter_pkg;

  localparam int CNT_MAX_WIDTH = 16;

  localparam logic MODE_FREE_RUN = 1'b0;
  localparam logic MODE_ONE_SHOT = 1'b1;

  // Mask with the low 'width' bits set; width 0 gives an empty mask.
  function automatic logic [CNT_MAX_WIDTH-1:0] cnt_all_ones(input int width);
    logic [CNT_MAX_WIDTH-1:0] v;
    v = '0;
    for (int b = 0; b < CNT_MAX_WIDTH; b++) begin
      if (b < width) v[b] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/synch_down_counter_t_ff.sv
// Toggle flip-flop cell: flips Q on a rising clk edge when T is high,
// cleared asynchronously by an active-low reset.
module t_ff (
  input  logic T,
  input  logic clk,
  input  logic reset_n,
  output logic Q
);

  logic q_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= 1'b0;
    end else if (T) begin
      q_q <= ~q_q;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/synch_down_counter.sv
// Loadable synchronous down counter built from a shared-clock T flip-flop
// chain, with free-run/one-shot mode, terminal-count pulse and sticky done.
module synch_down_counter
  import synch_down_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             one_shot,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             tc,
  output logic             done
);

  logic [WIDTH-1:0]         q_q;
  logic [WIDTH-1:0]         t_d;
  logic [CNT_MAX_WIDTH-1:0] q_ext;
  logic                     stop_at_zero;
  logic                     dec_en;
  logic                     at_one;
  logic                     tc_d, tc_q;
  logic                     done_d, done_q;

  assign q_ext        = CNT_MAX_WIDTH'(q_q);
  assign zero         = (q_q == '0);
  assign at_one       = (q_q == WIDTH'(1));
  assign stop_at_zero = (one_shot == MODE_ONE_SHOT) && zero;
  assign dec_en       = en && !stop_at_zero;

  // A bit borrows (toggles) on decrement when every lower bit is zero; from
  // all-zeros that flips every bit, which is exactly the free-run wrap.
  // A load toggles only the bits that differ from load_val.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam logic [CNT_MAX_WIDTH-1:0] LOW_MASK = cnt_all_ones(i);
    logic low_zero;
    assign low_zero = ((q_ext & LOW_MASK) == '0);
    assign t_d[i]   = load ? (q_q[i] ^ load_val[i]) : (dec_en & low_zero);

    t_ff u_tff (
      .T       (t_d[i]),
      .clk     (clk),
      .reset_n (reset_n),
      .Q       (q_q[i])
    );
  end

  always_comb begin
    tc_d   = 1'b0;
    done_d = done_q;
    if (load) begin
      done_d = 1'b0;
    end else if (en && at_one) begin
      tc_d = 1'b1;
      if (one_shot == MODE_ONE_SHOT) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tc_q   <= tc_d;
      done_q <= done_d;
    end
  end

  assign Q    = q_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule
